// File: rtl/eae_unit_pkg.sv
// Shared types and constants for the extended arithmetic element (EAE).
// Word width, step count, FSM states and the packed divide working state.
package eae_unit_pkg;

    localparam int EAE_WIDTH = 12;
    localparam int EAE_STEPS = 12;

    typedef enum logic [1:0] {
        EAE_IDLE,
        EAE_MUL,
        EAE_DVI,
        EAE_DONE
    } eae_state_t;

    // Remainder carries one guard bit so the shifted compare never loses a carry.
    typedef struct packed {
        logic [EAE_WIDTH:0]   rem;
        logic [EAE_WIDTH-1:0] quo;
    } div_state_t;

endpackage

// File: rtl/eae_unit_div_step.sv
// One restoring-division step: shift {rem, quo} left, subtract divisor if it fits.
// Purely combinational, zero latency, no flow control.
module eae_div_step
    import eae_unit_pkg::*;
(
    input  div_state_t             cur,
    input  logic [EAE_WIDTH-1:0]   divisor,
    output div_state_t             nxt
);

    logic [EAE_WIDTH+1:0] shifted;

    always_comb begin
        shifted  = {cur.rem, cur.quo[EAE_WIDTH-1]};
        nxt.rem  = shifted[EAE_WIDTH:0];
        nxt.quo  = {cur.quo[EAE_WIDTH-2:0], 1'b0};
        if (shifted >= {2'b00, divisor}) begin
            nxt.rem    = (EAE_WIDTH+1)'(shifted - {2'b00, divisor});
            nxt.quo[0] = 1'b1;
        end
    end

endmodule

// File: rtl/eae_unit.sv
// Iterative 12-bit unsigned multiply (MUY) / restoring divide (DVI) unit.
// Start->done 13 cycles (divide overflow: 1); no backpressure, starts outside IDLE are dropped.
module eae_unit
    import eae_unit_pkg::*;
#(
    parameter int WIDTH = EAE_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_mul,
    input  logic             start_dvi,
    input  logic [WIDTH-1:0] ac_in,
    input  logic [WIDTH-1:0] mq_in,
    input  logic [WIDTH-1:0] operand,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ac_mul,
    output logic [WIDTH-1:0] mq_mul,
    output logic [WIDTH-1:0] ac_dvi,
    output logic [WIDTH-1:0] mq_dvi,
    output logic             link_dvi
);

    eae_state_t       state_q, state_d;
    logic [3:0]       count_q;
    logic [WIDTH:0]   phi_q;
    logic [WIDTH-1:0] mpl_q;
    logic [WIDTH-1:0] opnd_q;
    logic [WIDTH:0]   mul_sum;
    div_state_t       div_q, div_nxt;
    logic             last_step;
    logic             dvi_ovf;

    assign last_step = (count_q == 4'(EAE_STEPS - 1));
    assign dvi_ovf   = (ac_in >= operand);
    assign mul_sum   = phi_q + (mpl_q[0] ? {1'b0, opnd_q} : '0);

    eae_div_step u_div_step (
        .cur     (div_q),
        .divisor (opnd_q),
        .nxt     (div_nxt)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= EAE_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EAE_IDLE: begin
                if (start_mul)      state_d = EAE_MUL;
                else if (start_dvi) state_d = dvi_ovf ? EAE_DONE : EAE_DVI;
            end
            EAE_MUL:  if (last_step) state_d = EAE_DONE;
            EAE_DVI:  if (last_step) state_d = EAE_DONE;
            EAE_DONE: state_d = EAE_IDLE;
            default:  state_d = EAE_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == EAE_MUL) || (state_q == EAE_DVI);
        done = (state_q == EAE_DONE);
    end

    // Results load only on the step that enters DONE; everything else holds.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= '0;
            phi_q    <= '0;
            mpl_q    <= '0;
            opnd_q   <= '0;
            div_q    <= '0;
            ac_mul   <= '0;
            mq_mul   <= '0;
            ac_dvi   <= '0;
            mq_dvi   <= '0;
            link_dvi <= 1'b0;
        end else begin
            case (state_q)
                EAE_IDLE: begin
                    if (start_mul) begin
                        mpl_q   <= mq_in;
                        opnd_q  <= operand;
                        phi_q   <= '0;
                        count_q <= '0;
                    end else if (start_dvi) begin
                        if (dvi_ovf) begin
                            ac_dvi   <= ac_in;
                            mq_dvi   <= mq_in;
                            link_dvi <= 1'b1;
                        end else begin
                            div_q   <= '{rem: {1'b0, ac_in}, quo: mq_in};
                            opnd_q  <= operand;
                            count_q <= '0;
                        end
                    end
                end
                EAE_MUL: begin
                    phi_q   <= {1'b0, mul_sum[WIDTH:1]};
                    mpl_q   <= {mul_sum[0], mpl_q[WIDTH-1:1]};
                    count_q <= count_q + 4'd1;
                    if (last_step) begin
                        ac_mul <= mul_sum[WIDTH:1];
                        mq_mul <= {mul_sum[0], mpl_q[WIDTH-1:1]};
                    end
                end
                EAE_DVI: begin
                    div_q   <= div_nxt;
                    count_q <= count_q + 4'd1;
                    if (last_step) begin
                        ac_dvi   <= div_nxt.rem[WIDTH-1:0];
                        mq_dvi   <= div_nxt.quo;
                        link_dvi <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
